// File: rtl/rgb_pwm_driver_if.sv
// rgb_pwm_driver_if: run/update controls, six duty inputs and the PWM/status outputs of the driver
interface rgb_pwm_driver_if;
  logic en;
  logic upd;
  logic [7:0] R1_in, G1_in, B1_in, R2_in, G2_in, B2_in;
  logic R1_pwm, G1_pwm, B1_pwm, R2_pwm, G2_pwm, B2_pwm;
  logic period_start;
  logic upd_pending;
  logic busy;
  modport master (
    output en, upd, R1_in, G1_in, B1_in, R2_in, G2_in, B2_in,
    input R1_pwm, G1_pwm, B1_pwm, R2_pwm, G2_pwm, B2_pwm, period_start, upd_pending, busy
  );
  modport slave (
    input en, upd, R1_in, G1_in, B1_in, R2_in, G2_in, B2_in,
    output R1_pwm, G1_pwm, B1_pwm, R2_pwm, G2_pwm, B2_pwm, period_start, upd_pending, busy
  );
endinterface

// File: rtl/rgb_pwm_driver.sv
// rgb_pwm_driver: six-channel 8-bit PWM with double-buffered duties applied at period wrap and drain-to-period-end stop
module rgb_pwm_driver #(
  parameter int PRESCALE = 4
) (
  input logic clk,
  input logic rst,
  rgb_pwm_driver_if.slave bus
);
  typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;
  localparam logic [7:0] PMAX = 8'(PRESCALE - 1);
  state_t state, state_n;
  logic [7:0] pres, pres_n, cnt, cnt_n;
  logic [5:0][7:0] din, pend, act;
  logic [5:0] lt, pwm;
  logic run, step, wrap, entry, bound, pending, pstart, busy_q;
  assign din = {bus.B2_in, bus.G2_in, bus.R2_in, bus.B1_in, bus.G1_in, bus.R1_in};
  assign run = state != IDLE;
  assign step = pres == PMAX;
  assign wrap = run && step && cnt == 8'hff;
  assign entry = state == IDLE && bus.en;
  assign bound = entry || wrap;
  for (genvar i = 0; i < 6; i++) begin : g_cmp
    assign lt[i] = cnt < act[i];
  end
  always_comb begin
    state_n = state == IDLE ? (bus.en ? RUN : IDLE)
            : state == RUN  ? (bus.en ? RUN : DRAIN)
            : wrap ? IDLE : bus.en ? RUN : DRAIN;
    pres_n = run && !step ? pres + 8'd1 : 8'd0;
    cnt_n = run ? cnt + {7'd0, step} : 8'd0;
  end
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= IDLE;
      pres <= '0;
      cnt <= '0;
      pend <= '0;
      act <= '0;
      pwm <= '0;
      pending <= 1'b0;
      pstart <= 1'b0;
      busy_q <= 1'b0;
    end else begin
      state <= state_n;
      pres <= pres_n;
      cnt <= cnt_n;
      if (bus.upd) pend <= din;
      if (bound) act <= bus.upd ? din : (entry || pending) ? pend : act;
      pending <= !bound && (pending || bus.upd);
      pwm <= run ? lt : 6'd0;
      pstart <= state_n != IDLE && pres_n == 8'd0 && cnt_n == 8'd0;
      busy_q <= state_n != IDLE;
    end
  end
  assign {bus.B2_pwm, bus.G2_pwm, bus.R2_pwm, bus.B1_pwm, bus.G1_pwm, bus.R1_pwm} = pwm;
  assign bus.period_start = pstart;
  assign bus.upd_pending = pending;
  assign bus.busy = busy_q;
endmodule

// File: doc/rgb_pwm_driver.md
RGB_PWM_DRIVER -- requirements
Module: rgb_pwm_driver

Interface
REQ-001 SHALL have parameter PRESCALE, default 4: clk cycles per PWM count step; legal range 1..255.
REQ-002 SHALL have port clk  input  1  sole clock; all state changes on its rising edge.
REQ-003 SHALL have port rst  input  1  asynchronous, active-low reset.
REQ-004 SHALL have port en  input  1  run request for the PWM engine.
REQ-005 SHALL have port upd  input  1  one-cycle strobe that captures the six duty inputs.
REQ-006 SHALL have ports R1_in, G1_in, B1_in, R2_in, G2_in, B2_in  input  8 each  duty values, 0..255.
REQ-007 SHALL have ports R1_pwm, G1_pwm, B1_pwm, R2_pwm, G2_pwm, B2_pwm  output  1 each  registered PWM outputs.
REQ-008 SHALL have port period_start  output  1  one-cycle pulse at each PWM period start.
REQ-009 SHALL have port upd_pending  output  1  captured duties not yet applied.
REQ-010 SHALL have port busy  output  1  high when the state is not IDLE.

Function
REQ-011 SHALL implement the states IDLE, RUN and DRAIN.
REQ-012 SHALL keep a prescaler pres (0..PRESCALE-1) and an 8-bit period counter cnt.
REQ-013 SHALL hold six pending and six active 8-bit duty registers.
REQ-014 IDLE SHALL hold pres=0 and cnt=0; en=1 SHALL move to RUN with pres=0, cnt=0, load active from pending, and clear upd_pending.
REQ-015 RUN and DRAIN SHALL count each cycle:
 - pres increments every cycle.
 - When pres==PRESCALE-1, pres returns to 0 and cnt increments.
 - cnt wraps 255->0 ("wrap").
REQ-016 At each wrap with upd_pending=1, active SHALL load from pending and upd_pending SHALL clear.
REQ-017 upd=1 SHALL write all six inputs to pending and set upd_pending in the same edge.
REQ-018 If upd coincides with a wrap or with IDLE->RUN entry, the current inputs SHALL go directly to active and upd_pending SHALL end at 0.
REQ-019 Each PWM output SHALL be registered as (state is RUN or DRAIN) AND (cnt < active duty), so it lags cnt by one cycle.
REQ-020 Duty 0 SHALL give a constant low output; duty 255 SHALL be high for 255 of 256 counts; duty d SHALL be high for d*PRESCALE cycles per period.
REQ-021 period_start SHALL be registered, high for one cycle after each edge where the new state is RUN or DRAIN with pres=0 and cnt=0, including RUN entry.
REQ-022 en=0 in RUN SHALL move to DRAIN; counting and outputs SHALL continue unchanged.
REQ-023 en=1 in DRAIN SHALL return to RUN without disturbing pres, cnt or active.
REQ-024 At a wrap in DRAIN, the state SHALL become IDLE and cnt SHALL be 0; all PWM outputs SHALL be 0 from the following cycle.
REQ-025 upd SHALL be accepted in every state; in IDLE it only updates pending.
REQ-026 busy SHALL be registered and equal to (state != IDLE).
REQ-027 PRESCALE=1 SHALL advance cnt every cycle, so the period is 256 cycles.

Reset
REQ-028 When rst=0, the block SHALL immediately, independent of clk, apply all of the following:
 - state = IDLE
 - pres = 0, cnt = 0
 - pending and active = 0
 - all PWM outputs, period_start, upd_pending and busy = 0
REQ-029 Reset asserted mid-period SHALL abort the period with no drain; the first edge after rst returns to 1 SHALL follow the IDLE rules.

Verification (PRESCALE=1 unless stated)
REQ-030 Bench SHALL check: upd with R1_in=64, all others 0, then en=1 -> period_start pulses; R1_pwm high exactly 64 consecutive cycles per 256-cycle period; other outputs stay 0.
REQ-031 Bench SHALL check: in RUN, upd with G2_in=128 at cnt=10 -> upd_pending=1 until wrap; G2_pwm unchanged in the current period; high 128 cycles in the next; upd_pending=0 after the wrap.
REQ-032 Bench SHALL check: en=0 at cnt=100 -> busy stays 1 through the wrap; outputs keep toggling to the period end; then state is IDLE, outputs 0, busy 0.
REQ-033 Bench SHALL check: duty 255 and duty 0 -> outputs high 255 of 256 cycles and constant 0, respectively.
REQ-034 Bench SHALL check: with PRESCALE=4, B1_in=3 -> B1_pwm high 12 cycles per 1024-cycle period; period_start spacing is 1024 cycles.
REQ-035 Bench SHALL check: rst pulsed low mid-cycle at cnt=50 -> all outputs 0 before the next clk edge; after release with en=1, the next period starts from cnt=0 with active=0.
